cell_free_list: RTL and testbench



---
 rtl/cell_free_list_if.sv | 25 ++
 rtl/cell_free_list.sv | 174 +++++++++++++++++
 tb/tb_cell_free_list.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cell_free_list_if.sv
// Alloc/free handshake between the cell allocator and its single arbitrated requester.
interface cell_free_list_if #(
   parameter int unsigned CELL_ID_W = 14
);
   logic                 alloc_req;
   logic [CELL_ID_W-1:0] alloc_id;
   logic                 alloc_valid;
   logic                 alloc_empty;
   logic                 free_req;
   logic [CELL_ID_W-1:0] free_id;
   logic [CELL_ID_W:0]   free_cnt;
   logic                 init_done;
   logic                 err_ovf;
   logic                 err_dbl;

   modport master (
      output alloc_req, free_req, free_id,
      input  alloc_id, alloc_valid, alloc_empty, free_cnt, init_done, err_ovf, err_dbl
   );

   modport slave (
      input  alloc_req, free_req, free_id,
      output alloc_id, alloc_valid, alloc_empty, free_cnt, init_done, err_ovf, err_dbl
   );
endinterface

// File: rtl/cell_free_list.sv
// FIFO free list of packet-buffer cell IDs; self-initialises after reset.
// Optional double-free checking bitmap: CELL_FREE_LIST_DBLFREE_CHK_EN.
module cell_free_list #(
   parameter int unsigned CELL_ID_W = 14,
   parameter int unsigned NUM_CELLS = 16384
) (
   input  logic             clk,
   input  logic             rst,
   cell_free_list_if.slave  fl
);

   localparam logic [CELL_ID_W-1:0] LAST_IDX = CELL_ID_W'(NUM_CELLS - 1);
   localparam logic [CELL_ID_W-1:0] PTR_ONE  = 1;
   localparam logic [CELL_ID_W:0]   FULL_CNT = (CELL_ID_W + 1)'(NUM_CELLS);
   localparam logic [CELL_ID_W:0]   CNT_ONE  = 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               r_state, w_state_nxt;
   logic [CELL_ID_W-1:0] r_init_idx, w_init_idx_nxt;
   logic [CELL_ID_W-1:0] r_head, w_head_nxt;
   logic [CELL_ID_W-1:0] r_tail, w_tail_nxt;
   logic [CELL_ID_W:0]   r_free_cnt, w_free_cnt_nxt;
   logic [CELL_ID_W-1:0] r_alloc_id, w_alloc_id_nxt;
   logic                 r_alloc_valid, w_alloc_valid_nxt;
   logic                 r_alloc_empty, w_alloc_empty_nxt;
   logic                 r_init_done, w_init_done_nxt;
   logic                 r_err_ovf, w_err_ovf_nxt;

   logic                 w_grant, w_accept, w_free_ovf, w_free_ok;
   logic                 w_mem_we;
   logic [CELL_ID_W-1:0] w_mem_waddr, w_mem_wdata;
   logic [CELL_ID_W-1:0] w_head_id;

   logic [CELL_ID_W-1:0] r_mem [NUM_CELLS];

   function automatic logic [CELL_ID_W-1:0] ptr_inc(input logic [CELL_ID_W-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PTR_ONE;
   endfunction

   // Async read of the head entry lets grants run back-to-back without a prefetch stage.
   assign w_head_id = r_mem[r_head];

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_init_idx_nxt    = r_init_idx;
      w_head_nxt        = r_head;
      w_tail_nxt        = r_tail;
      w_free_cnt_nxt    = r_free_cnt;
      w_alloc_id_nxt    = r_alloc_id;
      w_alloc_valid_nxt = 1'b0;
      w_grant           = 1'b0;
      w_accept          = 1'b0;
      w_free_ovf        = 1'b0;
      w_mem_we          = 1'b0;
      w_mem_waddr       = r_tail;
      w_mem_wdata       = fl.free_id;
      w_init_done_nxt   = r_init_done;

      case (r_state)
         ST_INIT: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_init_idx;
            w_mem_wdata = r_init_idx;
            w_free_ovf  = fl.free_req;
            if (r_init_idx == LAST_IDX) begin
               w_state_nxt     = ST_RUN;
               w_init_idx_nxt  = '0;
               w_head_nxt      = '0;
               w_tail_nxt      = '0;
               w_free_cnt_nxt  = FULL_CNT;
               w_init_done_nxt = 1'b1;
            end else begin
               w_init_idx_nxt = r_init_idx + PTR_ONE;
            end
         end
         ST_RUN: begin
            // Grant looks only at the registered count, so a same-cycle free never feeds an empty-list alloc.
            w_grant = fl.alloc_req && (r_free_cnt != '0);
            if (fl.free_req) begin
               if (r_free_cnt == FULL_CNT) w_free_ovf = 1'b1;
               else if (w_free_ok)         w_accept   = 1'b1;
            end
            if (w_grant) begin
               w_head_nxt        = ptr_inc(r_head);
               w_alloc_id_nxt    = w_head_id;
               w_alloc_valid_nxt = 1'b1;
            end
            if (w_accept) begin
               w_mem_we   = 1'b1;
               w_tail_nxt = ptr_inc(r_tail);
            end
            case ({w_grant, w_accept})
               2'b10:   w_free_cnt_nxt = r_free_cnt - CNT_ONE;
               2'b01:   w_free_cnt_nxt = r_free_cnt + CNT_ONE;
               default: w_free_cnt_nxt = r_free_cnt;
            endcase
         end
         default: w_state_nxt = ST_INIT;
      endcase

      w_err_ovf_nxt     = r_err_ovf | w_free_ovf;
      w_alloc_empty_nxt = (w_state_nxt == ST_INIT) || (w_free_cnt_nxt == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init_idx    <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_free_cnt    <= '0;
         r_alloc_id    <= '0;
         r_alloc_valid <= 1'b0;
         r_alloc_empty <= 1'b1;
         r_init_done   <= 1'b0;
         r_err_ovf     <= 1'b0;
      end else begin
         r_init_idx    <= w_init_idx_nxt;
         r_head        <= w_head_nxt;
         r_tail        <= w_tail_nxt;
         r_free_cnt    <= w_free_cnt_nxt;
         r_alloc_id    <= w_alloc_id_nxt;
         r_alloc_valid <= w_alloc_valid_nxt;
         r_alloc_empty <= w_alloc_empty_nxt;
         r_init_done   <= w_init_done_nxt;
         r_err_ovf     <= w_err_ovf_nxt;
      end
   end

`ifdef CELL_FREE_LIST_DBLFREE_CHK_EN
   logic [NUM_CELLS-1:0] r_alloc_map;
   logic                 r_err_dbl;
   logic                 w_free_dbl;

   // Only IDs currently handed out may come back; out-of-range IDs never match.
   assign w_free_ok  = ({1'b0, fl.free_id} < FULL_CNT) && r_alloc_map[fl.free_id];
   assign w_free_dbl = (r_state == ST_RUN) && fl.free_req && (r_free_cnt != FULL_CNT) && !w_free_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alloc_map <= '0;
         r_err_dbl   <= 1'b0;
      end else if (r_state == ST_INIT) begin
         r_alloc_map <= '0;
      end else begin
         if (w_accept) r_alloc_map[fl.free_id] <= 1'b0;
         if (w_grant)  r_alloc_map[w_head_id]  <= 1'b1;
         if (w_free_dbl) r_err_dbl <= 1'b1;
      end
   end

   assign fl.err_dbl = r_err_dbl;
`else
   assign w_free_ok  = 1'b1;
   assign fl.err_dbl = 1'b0;
`endif

   assign fl.alloc_id    = r_alloc_id;
   assign fl.alloc_valid = r_alloc_valid;
   assign fl.alloc_empty = r_alloc_empty;
   assign fl.free_cnt    = r_free_cnt;
   assign fl.init_done   = r_init_done;
   assign fl.err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_cell_free_list.sv
// Scoreboard bench for cell_free_list with 8 cells of 3-bit IDs.
module tb_cell_free_list;

   localparam int unsigned W = 3;
   localparam int unsigned N = 8;
`ifdef CELL_FREE_LIST_DBLFREE_CHK_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cell_free_list_if #(.CELL_ID_W(W)) u_if ();

   cell_free_list #(.CELL_ID_W(W), .NUM_CELLS(N)) u_dut (
      .clk (clk),
      .rst (rst),
      .fl  (u_if.slave)
   );

   int n_total = 0;
   int n_bad   = 0;

   int unsigned exp_q[$];
   int unsigned m_list[$];
   bit          m_run;
   int unsigned m_init_left;
   bit          m_ovf, m_dbl, m_valid;
   bit [N-1:0]  m_map;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("alloc_valid", u_if.alloc_valid, m_valid);
      if (u_if.alloc_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("grant_expected", exp_q.size(), 1);
         else                   chk("alloc_id", u_if.alloc_id, exp_q.pop_front());
      end
      chk("free_cnt", u_if.free_cnt, m_run ? m_list.size() : 0);
      chk("alloc_empty", u_if.alloc_empty, (!m_run || m_list.size() == 0));
      chk("init_done", u_if.init_done, m_run);
      chk("err_ovf", u_if.err_ovf, m_ovf);
      chk("err_dbl", u_if.err_dbl, m_dbl);
   endtask

   // Drive one cycle of requests, predict its effect, then compare after the edge.
   task automatic step(input bit a, input bit f, input int unsigned fid);
      bit grant, ovf, ok;
      u_if.alloc_req = a;
      u_if.free_req  = f;
      u_if.free_id   = fid[W-1:0];
      grant = m_run && a && (m_list.size() != 0);
      ovf   = f && (!m_run || m_list.size() == N);
      ok    = f && !ovf && (!DBL || (fid < N && m_map[fid]));
      m_valid = 1'b0;
      if (grant) begin
         exp_q.push_back(m_list.pop_front());
         m_map[exp_q[$]] = 1'b1;
         m_valid = 1'b1;
      end
      if (ok) begin
         m_list.push_back(fid);
         m_map[fid] = 1'b0;
      end
      if (ovf) m_ovf = 1'b1;
      if (f && !ovf && !ok) m_dbl = 1'b1;
      @(posedge clk);
      #1;
      u_if.alloc_req = 1'b0;
      u_if.free_req  = 1'b0;
      if (!m_run) begin
         m_init_left--;
         if (m_init_left == 0) begin
            m_run = 1'b1;
            for (int unsigned k = 0; k < N; k++) m_list.push_back(k);
         end
      end
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      chk("rst_alloc_valid", u_if.alloc_valid, 0);
      chk("rst_alloc_id", u_if.alloc_id, 0);
      chk("rst_alloc_empty", u_if.alloc_empty, 1);
      chk("rst_free_cnt", u_if.free_cnt, 0);
      chk("rst_init_done", u_if.init_done, 0);
      chk("rst_err_ovf", u_if.err_ovf, 0);
      chk("rst_err_dbl", u_if.err_dbl, 0);
      m_run = 1'b0;
      m_init_left = N;
      m_ovf = 1'b0;
      m_dbl = 1'b0;
      m_valid = 1'b0;
      m_map = '0;
      m_list.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      u_if.alloc_req = 1'b0;
      u_if.free_req  = 1'b0;
      u_if.free_id   = '0;
      #1;

      // Init sweep, then a free into the full list.
      do_reset();
      for (int i = 0; i < int'(N); i++) step(1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b0, 0);

      // Drain with a held request: IDs 0..7, then no ninth grant.
      repeat (N + 1) step(1'b1, 1'b0, 0);

      // Free into an empty list alongside an alloc.
      step(1'b1, 1'b1, 5);
      step(1'b1, 1'b0, 0);

      // Refill to 4, then concurrent alloc+free of ID 2.
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b1, 4);
      repeat (3) step(1'b1, 1'b1, 2);
      for (int i = 0; i < int'(N) + 2; i++) step(1'b1, 1'b0, 0);

      // Free during INIT, then double free of ID 0.
      do_reset();
      for (int i = 0; i < int'(N); i++) step(1'b0, (i == 3), 3);
      step(1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 0);

      // Reset while a grant is being presented; INIT must ignore allocs and restart from ID 0.
      step(1'b1, 1'b0, 0);
      do_reset();
      for (int i = 0; i < int'(N); i++) step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);

      chk("sb_left", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
